// File: rtl/eq_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : eq_i2s_tx
// Brief    : I2S master transmitter for the equalizer output, 24-bit in 32-bit slots.
// Revision : 1.0
// ============================================================================
module eq_i2s_tx #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [23:0] l_data_in,
  input  logic [23:0] r_data_in,
  input  logic        mute,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        frame_start,
  output logic        underrun,
  output logic        overrun
);

  localparam int SLOT_W = $clog2(SLOT_BITS);
  localparam int CNT_W  = SLOT_W + 1;

  logic [7:0]        div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [23:0]       frame_l;
  logic [23:0]       frame_r;
  logic [23:0]       hold_l;
  logic [23:0]       hold_r;
  logic              pending;
  logic              mute_frame;

  logic              tick;
  logic              fall;
  logic              load;
  logic [CNT_W-1:0]  next_cnt;
  logic [SLOT_W-1:0] slot_k;
  logic [SLOT_W-1:0] data_idx;
  logic [23:0]       slot_word;
  logic              next_sdata;

  assign tick        = (div_cnt == 8'(BCLK_DIV - 1));
  assign fall        = tick & bclk;
  assign load        = fall & (bit_cnt == {CNT_W{1'b1}});
  assign frame_start = load;
  assign underrun    = load & ~sample_valid & ~pending;
  // A strobe landing on the load point is consumed directly, so it never overruns.
  assign overrun     = sample_valid & pending & ~load;

  // Serial bit for the bit counter value that the coming fall event moves to.
  always_comb begin
    next_cnt   = bit_cnt + CNT_W'(1);
    slot_k     = next_cnt[SLOT_W-1:0];
    slot_word  = next_cnt[SLOT_W] ? frame_r : frame_l;
    data_idx   = SLOT_W'(24) - slot_k;
    next_sdata = 1'b0;
    if (!mute_frame && (slot_k != '0) && (slot_k <= SLOT_W'(24))) begin
      next_sdata = slot_word[data_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= {CNT_W{1'b1}};
      lrclk   <= 1'b1;
      sdata   <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 8'd1;
      if (tick) begin
        bclk <= ~bclk;
      end
      if (fall) begin
        bit_cnt <= next_cnt;
        lrclk   <= next_cnt[SLOT_W];
        sdata   <= next_sdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_l    <= '0;
      frame_r    <= '0;
      hold_l     <= '0;
      hold_r     <= '0;
      pending    <= 1'b0;
      mute_frame <= 1'b0;
    end else if (load) begin
      mute_frame <= mute;
      pending    <= 1'b0;
      if (sample_valid) begin
        frame_l <= l_data_in;
        frame_r <= r_data_in;
      end else if (pending) begin
        frame_l <= hold_l;
        frame_r <= hold_r;
      end
      // With neither source the previous frame registers are retransmitted.
    end else if (sample_valid) begin
      hold_l  <= l_data_in;
      hold_r  <= r_data_in;
      pending <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eq_i2s_tx.sv
`default_nettype none
// Directed self-checking bench for eq_i2s_tx at BCLK_DIV = 4.
module tb_eq_i2s_tx;

  localparam int B = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [23:0] l_data_in;
  logic [23:0] r_data_in;
  logic        mute;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        frame_start;
  logic        underrun;
  logic        overrun;

  int checks = 0;
  int fails  = 0;

  eq_i2s_tx #(.BCLK_DIV(B), .SLOT_BITS(32)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
    .l_data_in(l_data_in), .r_data_in(r_data_in), .mute(mute),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .frame_start(frame_start),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Frame as seen on sdata, first bit of the left slot in bit 63.
  function automatic logic [63:0] frame_of(input logic [23:0] lv, input logic [23:0] rv);
    return {1'b0, lv, 7'b0, 1'b0, rv, 7'b0};
  endfunction

  // Advances at least one cycle; returns at the negedge where frame_start is high.
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 1000);
    check("frame_start_seen", 64'(frame_start), 64'd1);
  endtask

  // Called at a frame_start negedge; records sdata/lrclk at each of nbits fall events.
  task automatic capture(input int nbits, output logic [63:0] d, output logic [63:0] lr);
    logic prev;
    int   falls;
    int   waited;
    d = '0;
    lr = '0;
    falls = 0;
    prev = bclk;
    for (int i = 0; i < nbits; i++) begin
      waited = 0;
      while (waited < 4 * B) begin
        @(negedge clk);
        sample_valid = 1'b0;
        mute = 1'b0;
        waited++;
        if (prev && !bclk) begin
          prev = bclk;
          break;
        end
        prev = bclk;
      end
      if (waited >= 4 * B && prev) break;
      d[63-i]  = sdata;
      lr[63-i] = lrclk;
      falls++;
    end
    check("capture_falls", 64'(falls), 64'(nbits));
  endtask

  initial begin
    int n;
    logic [63:0] d;
    logic [63:0] lr;

    reset_n = 1'b0;
    sample_valid = 1'b0;
    l_data_in = '0;
    r_data_in = '0;
    mute = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bclk, lrclk, sdata, frame_start, underrun, overrun}), 64'b010000);

    // Release: load edge is the 2*B-th rising edge; first load has nothing to send.
    reset_n = 1'b1;
    wait_fs(n);
    check("first_load_edge", 64'(n + 1), 64'(2 * B));
    check("first_underrun", 64'(underrun), 64'd1);

    @(negedge clk);
    sample_valid = 1'b1;
    l_data_in = 24'h800001;
    r_data_in = 24'h7FFFFE;
    #1 check("single_strobe_no_overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    sample_valid = 1'b0;
    wait_fs(n);
    check("frame_period", 64'(n + 2), 64'(128 * B));
    check("buffered_no_underrun", 64'(underrun), 64'd0);
    capture(64, d, lr);
    check("frame_800001_7ffffe", d, frame_of(24'h800001, 24'h7FFFFE));
    check("lrclk_pattern", lr, {32'h0, 32'hFFFF_FFFF});

    // One load of 0x123456 then two frames without samples.
    @(negedge clk);
    sample_valid = 1'b1;
    l_data_in = 24'h123456;
    r_data_in = 24'h654321;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_fs(n);
    check("load_123456_no_underrun", 64'(underrun), 64'd0);
    wait_fs(n);
    check("retx1_underrun", 64'(underrun), 64'd1);
    capture(64, d, lr);
    check("retx1_data", d, frame_of(24'h123456, 24'h654321));
    wait_fs(n);
    check("retx2_underrun", 64'(underrun), 64'd1);
    capture(64, d, lr);
    check("retx2_data", d, frame_of(24'h123456, 24'h654321));

    // Two strobes inside one frame: the second overwrites and flags overrun.
    @(negedge clk);
    sample_valid = 1'b1;
    l_data_in = 24'h000001;
    r_data_in = 24'h000000;
    #1 check("ovr_first_strobe", 64'(overrun), 64'd0);
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sample_valid = 1'b1;
    l_data_in = 24'h000002;
    r_data_in = 24'h000003;
    #1 check("ovr_second_strobe", 64'(overrun), 64'd1);
    @(negedge clk);
    sample_valid = 1'b0;
    #1 check("ovr_is_pulse", 64'(overrun), 64'd0);
    wait_fs(n);
    check("ovr_load_no_underrun", 64'(underrun), 64'd0);
    capture(64, d, lr);
    check("ovr_frame_data", d, frame_of(24'h000002, 24'h000003));

    // Strobe coincident with the load point goes straight into the frame.
    wait_fs(n);
    sample_valid = 1'b1;
    l_data_in = 24'h00ABCD;
    r_data_in = 24'h00FF00;
    #1 check("direct_flags", 64'({underrun, overrun}), 64'b00);
    capture(64, d, lr);
    check("direct_data", d, frame_of(24'h00ABCD, 24'h00FF00));
    wait_fs(n);
    check("direct_left_no_pending", 64'(underrun), 64'd1);

    // Muted frame with full-scale data, reset at bit counter 40.
    mute = 1'b1;
    sample_valid = 1'b1;
    l_data_in = 24'hFFFFFF;
    r_data_in = 24'hFFFFFF;
    capture(41, d, lr);
    check("mute_zeros", d, 64'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("midframe_reset_outputs", 64'({bclk, lrclk, sdata, frame_start, underrun, overrun}), 64'b010000);
    repeat (5) @(negedge clk);
    check("reset_hold_outputs", 64'({bclk, lrclk, sdata, frame_start, underrun, overrun}), 64'b010000);
    reset_n = 1'b1;
    wait_fs(n);
    check("reload_edge_after_reset", 64'(n + 1), 64'(2 * B));
    check("reload_underrun", 64'(underrun), 64'd1);
    capture(64, d, lr);
    check("no_resume_after_reset", d, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
